constraint_sample_sequencer: RTL and testbench
==============================================

# constraint_sample_sequencer

Sequential controller that drives a combinational constraint checker: it generates pseudo-random candidate assignments with a seeded xorshift32 generator, presents each candidate on `cand`, waits for the checker's single-bit verdict, and offers passing candidates as samples over a valid/ready handshake. It counts attempts per sample and aborts with a timeout when the retry budget runs out. The checker itself is external: `cand` is split into the checker's `var_*` inputs, and the checker's `x` feeds back to `chk_ok`.

## Interface
- `VEC_W`, 64: total candidate width, equal to the sum of the checker input widths; must be at least 32.
- `CHK_LAT`, 1: cycles between a stable `cand` and a valid `chk_ok`; must be at least 1.
- `MAX_TRIES`, 1024: number of failed attempts per sample before timeout.
- `CNT_W`, 16: width of the try and sample counters.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a run; ignored while `busy`=1.
- `seed` in 32: generator seed, captured on an accepted `start`.
- `num_samples` in CNT_W: number of samples to deliver in the run.
- `cand` out VEC_W: candidate vector driven to the checker.
- `chk_ok` in 1: checker verdict for the current `cand`.
- `smp_valid` out 1: a sample is offered.
- `smp_ready` in 1: consumer accepts the offered sample.
- `smp_data` out VEC_W: the offered sample.
- `busy` out 1: high in every state other than IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `timeout` out 1: sticky flag, set when a run aborts; cleared by the next accepted `start`.
- `tries` out CNT_W: failed attempts for the current sample.
- `accepted` out CNT_W: samples handed off in the current run.

## Operation
**Reset values.** Asynchronous reset forces `cand`=0, `smp_data`=0, `smp_valid`=0, `busy`=0, `done`=0, `timeout`=0, `tries`=0, `accepted`=0, generator state=32'h1, FSM=IDLE. Reset mid-run abandons the run with no `done` pulse.

**Generator.** xorshift32, one step per FILL cycle:
- s ^= s<<13; s ^= s>>17; s ^= s<<5. The step output is the new s.
- A seed of 0 is loaded as 32'h1.

**FSM states.**
- IDLE: on `start`, clear `timeout`, `tries` and `accepted`, and load the seed.
  - If `num_samples`=0, go to DONE.
  - Otherwise go to FILL.
- FILL: lasts W = ceil(VEC_W/32) cycles. Each cycle computes `cand` <= {`cand`, step_output} truncated to the low VEC_W bits, so the first word ends up most significant. Then go to CHECK.
- CHECK: lasts CHK_LAT cycles with `cand` held stable. `chk_ok` is sampled on the last CHECK cycle.
  - If `chk_ok`=1: `smp_data` <= `cand`, go to OFFER.
  - If `chk_ok`=0: `tries`++. If the new `tries` equals MAX_TRIES, set `timeout` and go to DONE; otherwise go to FILL.
- OFFER: `smp_valid`=1 while `smp_data` and `cand` are held stable. On a cycle with `smp_ready`=1:
  - `accepted`++ and `tries` <= 0.
  - If the new `accepted` equals `num_samples`, go to DONE; otherwise go to FILL.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.

**Counters and width rules.**
- Counters saturate at all-ones and never wrap.
- `num_samples` is captured at start; later changes to the input are ignored.
- `start` is ignored while `busy`=1. A `start` in the DONE cycle is also ignored.

## Timing
- Accepted `start` at edge k: `busy`=1 from cycle k+1, with the first FILL in that same cycle.
- One attempt takes W+CHK_LAT cycles. `smp_valid` rises in the cycle after the last CHECK cycle.
- Handshake: the transfer happens on an edge where `smp_valid`=1 and `smp_ready`=1. `smp_valid` drops in the following cycle; the next FILL starts in that same cycle, or DONE if the run is complete.
- `smp_ready` held high: sustained throughput of one sample per W+CHK_LAT+1 cycles when every attempt passes.
- `smp_ready` low: OFFER holds indefinitely and no further attempts are made.
- Timeout: DONE follows the CHECK cycle that produced failure number MAX_TRIES; `done` and `timeout` are both 1 in that DONE cycle.

## Test plan
- Generator and fill order: VEC_W=64, CHK_LAT=1, `seed`=1, `chk_ok` tied 1, `num_samples`=1, `smp_ready`=1 → `smp_valid` rises 4 cycles after the `start` edge with `smp_data`=64'h00042021_04080601; `done` pulses once; `accepted`=1.
- Zero seed and zero count: `seed`=0 gives the same first sample as `seed`=1. `num_samples`=0 → `done` pulses the cycle after `start`, `smp_valid` never rises.
- Retry then pass: `chk_ok` is 0 for the first 3 verdicts, then 1 → `tries` reads 3 in OFFER; the sample equals the 4th candidate (generator steps 7–8 for seed 1); `tries` returns to 0 after the handshake.
- Timeout: MAX_TRIES=4, `chk_ok` tied 0 → `done` and `timeout` both 1 after the 4th CHECK; `accepted`=0; the next `start` clears `timeout`.
- Backpressure: `num_samples`=3, `chk_ok`=1, `smp_ready` low for 10 cycles on the 2nd offer → `smp_data` and `cand` stay stable, no generator steps occur, exactly 3 transfers, then `done`.
- Reset mid-run: assert `rst` during CHECK → all outputs take their reset values immediately; `start` ignored while `busy`; a fresh run after reset reproduces the same samples for the same seed.

Source files
------------

// File: rtl/constraint_sample_sequencer.sv
`timescale 1ns/1ps
// constraint_sample_sequencer
// Generates xorshift32 candidate vectors and presents them to an external
// combinational constraint checker. Candidates that pass are offered over a
// valid/ready handshake. Each run delivers num_samples samples, or aborts
// with a sticky timeout once one sample has failed MAX_TRIES times.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   start        : run request (ignored while busy, including the DONE cycle)
//   seed         : generator seed, captured on an accepted start (0 -> 1)
//   num_samples  : samples to deliver, captured on an accepted start
//   cand         : candidate vector driven to the checker
//   chk_ok       : checker verdict for cand
//   smp_valid    : sample offered
//   smp_ready    : consumer accepts the offered sample
//   smp_data     : offered sample
//   busy         : high in every state other than IDLE
//   done         : one-cycle end-of-run pulse
//   timeout      : sticky abort flag, cleared by the next accepted start
//   tries        : failed attempts for the current sample
//   accepted     : samples handed off in the current run
module constraint_sample_sequencer #(
  parameter int unsigned VEC_W     = 64,
  parameter int unsigned CHK_LAT   = 1,
  parameter int unsigned MAX_TRIES = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_samples,
  output logic [VEC_W-1:0] cand,
  input  logic             chk_ok,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic [VEC_W-1:0] smp_data,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] tries,
  output logic [CNT_W-1:0] accepted
);

  localparam int unsigned W       = (VEC_W + 31) / 32;
  localparam int unsigned FILL_CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned CHK_CW  = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

  localparam logic [FILL_CW-1:0] FILL_LAST   = FILL_CW'(W - 1);
  localparam logic [CHK_CW-1:0]  CHK_LAST    = CHK_CW'(CHK_LAT - 1);
  localparam logic [CNT_W-1:0]   TRIES_LIMIT = CNT_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CHECK,
    S_OFFER,
    S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        gen;
  logic [CNT_W-1:0]   num_q;
  logic [FILL_CW-1:0] fill_cnt;
  logic [CHK_CW-1:0]  chk_cnt;

  logic [31:0]        step;
  logic [31:0]        seed_load;
  logic [VEC_W-1:0]   cand_shift;
  logic [CNT_W-1:0]   tries_inc;
  logic [CNT_W-1:0]   acc_inc;

  // One xorshift32 step (13, 17, 5).
  function automatic logic [31:0] xs32(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  assign step      = xs32(gen);
  // An all-zero state would lock the generator at zero.
  assign seed_load = (seed == 32'd0) ? 32'h1 : seed;

  // Shift the new word in at the bottom so the first word ends up on top.
  generate
    if (VEC_W > 32) begin : g_wide
      assign cand_shift = {cand[VEC_W-33:0], step};
    end else begin : g_narrow
      assign cand_shift = step;
    end
  endgenerate

  // Saturating increments.
  assign tries_inc = (&tries)    ? tries    : tries    + CNT_W'(1);
  assign acc_inc   = (&accepted) ? accepted : accepted + CNT_W'(1);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      gen       <= 32'h1;
      num_q     <= '0;
      fill_cnt  <= '0;
      chk_cnt   <= '0;
      cand      <= '0;
      smp_data  <= '0;
      smp_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      tries     <= '0;
      accepted  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            timeout  <= 1'b0;
            tries    <= '0;
            accepted <= '0;
            gen      <= seed_load;
            num_q    <= num_samples;
            busy     <= 1'b1;
            fill_cnt <= '0;
            if (num_samples == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_FILL;
            end
          end
        end

        S_FILL: begin
          gen  <= step;
          cand <= cand_shift;
          if (fill_cnt == FILL_LAST) begin
            fill_cnt <= '0;
            chk_cnt  <= '0;
            state    <= S_CHECK;
          end else begin
            fill_cnt <= fill_cnt + FILL_CW'(1);
          end
        end

        // cand is held here; the verdict is taken on the last cycle only.
        S_CHECK: begin
          if (chk_cnt == CHK_LAST) begin
            if (chk_ok) begin
              smp_data  <= cand;
              smp_valid <= 1'b1;
              state     <= S_OFFER;
            end else begin
              tries <= tries_inc;
              if (tries_inc == TRIES_LIMIT) begin
                timeout <= 1'b1;
                done    <= 1'b1;
                state   <= S_DONE;
              end else begin
                fill_cnt <= '0;
                state    <= S_FILL;
              end
            end
          end else begin
            chk_cnt <= chk_cnt + CHK_CW'(1);
          end
        end

        S_OFFER: begin
          if (smp_ready) begin
            smp_valid <= 1'b0;
            accepted  <= acc_inc;
            tries     <= '0;
            if (acc_inc == num_q) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              fill_cnt <= '0;
              state    <= S_FILL;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_constraint_sample_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for constraint_sample_sequencer (VEC_W=64, CHK_LAT=1,
// MAX_TRIES=4). The checker is modelled as: tied 0, tied 1, or "pass only
// when cand equals target".
module tb_constraint_sample_sequencer;

  localparam int unsigned VEC_W = 64;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [31:0]      seed;
  logic [CNT_W-1:0] num_samples;
  logic [VEC_W-1:0] cand;
  logic             chk_ok;
  logic             smp_valid;
  logic             smp_ready;
  logic [VEC_W-1:0] smp_data;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] tries;
  logic [CNT_W-1:0] accepted;

  logic [1:0]       chk_mode;
  logic [VEC_W-1:0] target;

  int n_err;
  int n_chk;

  constraint_sample_sequencer #(
    .VEC_W    (VEC_W),
    .CHK_LAT  (1),
    .MAX_TRIES(4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .num_samples(num_samples),
    .cand       (cand),
    .chk_ok     (chk_ok),
    .smp_valid  (smp_valid),
    .smp_ready  (smp_ready),
    .smp_data   (smp_data),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .tries      (tries),
    .accepted   (accepted)
  );

  assign chk_ok = (chk_mode == 2'd1) | ((chk_mode == 2'd2) & (cand == target));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // Reference xorshift32 model.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] a;
    a = s ^ {s[18:0], 13'b0};
    a = a ^ {17'b0, a[31:17]};
    a = a ^ {a[26:0], 5'b0};
    return a;
  endfunction

  // k-th candidate (1-based) produced after a start with the given seed.
  function automatic logic [63:0] cand_of(input logic [31:0] sd, input int k);
    logic [31:0] s;
    logic [31:0] hi;
    s  = (sd == 32'd0) ? 32'd1 : sd;
    hi = 32'd0;
    for (int i = 1; i <= 2 * k; i++) begin
      s = ref_step(s);
      if (i == 2 * k - 1) hi = s;
    end
    return {hi, s};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] sd, input logic [CNT_W-1:0] n);
    seed        = sd;
    num_samples = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(done), 64'd1);
    tick();
  endtask

  typedef struct {
    logic [31:0]      seed;
    logic [CNT_W-1:0] nsmp;
    logic [63:0]      exp_first;
    int               xfers;
  } vec_t;

  vec_t vecs[5];

  // Run one table vector with the checker tied to pass and ready held high.
  task automatic run_vec(input vec_t v, input int idx);
    int          cyc;
    int          first_lat;
    int          xfers;
    int          dones;
    logic [63:0] first;
    string       tag;
    tag       = $sformatf("vec%0d", idx);
    chk_mode  = 2'd1;
    smp_ready = 1'b1;
    pulse_start(v.seed, v.nsmp);
    cyc       = 1;
    first_lat = -1;
    xfers     = 0;
    dones     = 0;
    first     = '0;
    while (cyc < 200) begin
      if (smp_valid && first_lat < 0) begin
        first_lat = cyc;
        first     = smp_data;
      end
      if (smp_valid && smp_ready) begin
        check({tag, "_sample"}, smp_data, cand_of(v.seed, xfers + 1));
        xfers++;
      end
      if (done) begin
        dones++;
        break;
      end
      tick();
      cyc++;
    end
    check({tag, "_done"}, 64'(dones), 64'd1);
    check({tag, "_xfers"}, 64'(xfers), 64'(v.xfers));
    check({tag, "_accepted"}, 64'(accepted), 64'(v.nsmp));
    if (v.nsmp != '0) begin
      check({tag, "_valid_lat"}, 64'(first_lat), 64'd4);
      check({tag, "_first"}, first, v.exp_first);
    end else begin
      check({tag, "_done_lat"}, 64'(cyc), 64'd1);
      check({tag, "_no_valid"}, 64'(first_lat < 0), 64'd1);
    end
    tick();
    check({tag, "_done_drop"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    int          cyc;
    int          xfers;
    int          dones;
    int          stall_bad;
    int          n;
    logic        stalled;
    logic        saw_valid;
    logic [63:0] held;
    logic [63:0] held_c;

    n_err       = 0;
    n_chk       = 0;
    rst         = 1'b1;
    start       = 1'b0;
    seed        = '0;
    num_samples = '0;
    smp_ready   = 1'b0;
    chk_mode    = 2'd0;
    target      = '0;

    vecs[0] = '{32'd1,         16'd1, 64'h00042021_04080601, 1};
    vecs[1] = '{32'd0,         16'd1, 64'h00042021_04080601, 1};
    vecs[2] = '{32'd1,         16'd2, 64'h00042021_04080601, 2};
    vecs[3] = '{32'hDEADBEEF,  16'd1, cand_of(32'hDEADBEEF, 1), 1};
    vecs[4] = '{32'd5,         16'd0, 64'd0, 0};

    // Reset values
    repeat (3) tick();
    check("rst_cand", cand, 64'd0);
    check("rst_smp_data", smp_data, 64'd0);
    check("rst_smp_valid", 64'(smp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_tries", 64'(tries), 64'd0);
    check("rst_accepted", 64'(accepted), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Retry then pass: only the 4th candidate satisfies the checker.
    chk_mode  = 2'd2;
    target    = cand_of(32'd1, 4);
    smp_ready = 1'b0;
    pulse_start(32'd1, 16'd1);
    cyc = 1;
    while (!smp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("retry_valid", 64'(smp_valid), 64'd1);
    check("retry_lat", 64'(cyc), 64'd13);
    check("retry_tries", 64'(tries), 64'd3);
    check("retry_data", smp_data, target);
    check("retry_cand", cand, target);
    smp_ready = 1'b1;
    tick();
    check("retry_valid_drop", 64'(smp_valid), 64'd0);
    check("retry_tries_clr", 64'(tries), 64'd0);
    check("retry_accepted", 64'(accepted), 64'd1);
    check("retry_done", 64'(done), 64'd1);
    tick();

    // Timeout: checker tied to fail, MAX_TRIES=4.
    chk_mode  = 2'd0;
    saw_valid = 1'b0;
    pulse_start(32'd7, 16'd2);
    cyc = 1;
    while (!done && cyc < 100) begin
      if (smp_valid) saw_valid = 1'b1;
      tick();
      cyc++;
    end
    check("to_done", 64'(done), 64'd1);
    check("to_lat", 64'(cyc), 64'd13);
    check("to_flag", 64'(timeout), 64'd1);
    check("to_accepted", 64'(accepted), 64'd0);
    check("to_tries", 64'(tries), 64'd4);
    check("to_no_valid", 64'(saw_valid), 64'd0);
    // start during the DONE cycle must be ignored
    pulse_start(32'd3, 16'd1);
    check("to_done_start_busy", 64'(busy), 64'd0);
    check("to_sticky", 64'(timeout), 64'd1);
    chk_mode = 2'd1;
    pulse_start(32'd3, 16'd1);
    check("to_clear", 64'(timeout), 64'd0);
    check("to_restart_busy", 64'(busy), 64'd1);
    wait_done("to_rerun_done");

    // Backpressure on the 2nd offer; num_samples changes after start.
    chk_mode  = 2'd1;
    smp_ready = 1'b1;
    pulse_start(32'h1234, 16'd3);
    num_samples = 16'd0;
    cyc     = 1;
    xfers   = 0;
    dones   = 0;
    stalled = 1'b0;
    while (cyc < 300) begin
      if (smp_valid) begin
        if (xfers == 1 && !stalled) begin
          stalled   = 1'b1;
          held      = smp_data;
          held_c    = cand;
          smp_ready = 1'b0;
          stall_bad = 0;
          repeat (10) begin
            tick();
            cyc++;
            if (!smp_valid || smp_data !== held || cand !== held_c) stall_bad++;
          end
          check("bp_hold", 64'(stall_bad), 64'd0);
          smp_ready = 1'b1;
        end
        check("bp_data", smp_data, cand_of(32'h1234, xfers + 1));
        xfers++;
      end
      if (done) begin
        dones++;
        break;
      end
      tick();
      cyc++;
    end
    check("bp_stalled", 64'(stalled), 64'd1);
    check("bp_xfers", 64'(xfers), 64'd3);
    check("bp_accepted", 64'(accepted), 64'd3);
    check("bp_done", 64'(dones), 64'd1);
    tick();

    // Reset during CHECK.
    pulse_start(32'd1, 16'd2);
    tick();
    tick();
    check("rr_cand_pre", cand, 64'h00042021_04080601);
    rst = 1'b1;
    #1;
    check("rr_cand", cand, 64'd0);
    check("rr_smp_data", smp_data, 64'd0);
    check("rr_flags", 64'({busy, done, smp_valid, timeout}), 64'd0);
    check("rr_counts", 64'({tries, accepted}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    smp_ready = 1'b0;
    pulse_start(32'd1, 16'd1);
    n = 0;
    while (!smp_valid && n < 50) begin
      tick();
      n++;
    end
    check("rr_valid", 64'(smp_valid), 64'd1);
    check("rr_sample", smp_data, 64'h00042021_04080601);
    // start while busy must not disturb the run
    pulse_start(32'h99, 16'd5);
    check("rr_busy_start", 64'({busy, smp_valid}), 64'd3);
    check("rr_busy_data", smp_data, 64'h00042021_04080601);
    smp_ready = 1'b1;
    tick();
    check("rr_done", 64'(done), 64'd1);
    check("rr_accepted", 64'(accepted), 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
